// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V controller:
// FSM states, opcodes, immediate formats and ALU operation codes.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, LUI
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM; FUNCT defers to funct3/funct7.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic [2:0] imm_fmt(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE: return IMM_I;
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_LUI:            return IMM_U;
            OP_JAL:            return IMM_J;
            default:           return IMM_I;
        endcase
    endfunction

    function automatic logic is_known_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_LUI: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's coarse alu_op plus the
// instruction's funct fields onto a concrete ALU operation.
module alu_decoder (
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op_b5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);
    import mc_pkg::*;

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type (op[5] set) may select sub; addi never does.
                    3'b000:  alu_control_o = (op_b5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore-style main controller for a multi-cycle RV32 subset datapath.
// The state register is the only storage; all outputs decode from it.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       illegal,
    output state_e     state_o
);

    state_e     state_q, state_d, out_state;
    logic       pc_update, branch;
    logic       ir_write_s, mem_write_s, reg_write_s;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_LUI:            state_d = LUI;
                    default:           state_d = FETCH;
                endcase
            end
            MEMADR:                        state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:                       state_d = MEMWB;
            EXECUTER, EXECUTEI, JAL, LUI:  state_d = ALUWB;
            MEMWB, MEMWRITE, ALUWB, BRANCH: state_d = FETCH;
            default:                       state_d = FETCH;
        endcase
    end

    // While reset is held the mux selects present their FETCH values.
    assign out_state = rst ? FETCH : state_q;

    always_comb begin
        ir_write_s  = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = ALUOP_ADD;
        case (out_state)
            FETCH: begin
                ir_write_s = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: adr_src = 1'b1;
            MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: reg_write_s = 1'b1;
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op_b5_i       (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

    // funct3[0] distinguishes bne from beq, inverting the sense of zero.
    assign pc_write  = ~rst & (pc_update | (branch & (zero ^ funct3[0])));
    assign ir_write  = ~rst & ir_write_s;
    assign mem_write = ~rst & mem_write_s;
    assign reg_write = ~rst & reg_write_s;
    assign illegal   = ~rst & (state_q == DECODE) & ~is_known_op(op);
    assign imm_src   = imm_fmt(op);
    assign state_o   = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed vector table, hand-written
// reset sequences and random instructions against an instruction-level model.
module tb_mc_controller;
    import mc_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [2:0] imm_src;
        logic       illegal;
    } out_t;
    localparam int OW = $bits(out_t);

    typedef struct {
        logic [31:0] instr;
        logic        z;
        int          lat;
        int          nreg;
        int          nmem;
        int          npc;
        int          nill;
        logic [2:0]  alu3;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    state_e     state_o;
    out_t       got;

    logic [OW-1:0] exp_q[$];
    state_e        seen_st[$];
    int            checks = 0;
    int            errors = 0;

    mc_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
        .illegal(illegal), .state_o(state_o)
    );

    assign got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, alu_control, imm_src, illegal};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, g, e);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_imm(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011: return 3'b000;
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b0110111:             return 3'b011;
            7'b1101111:             return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic out_t mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                                input logic rw, input logic [1:0] res, input logic [1:0] a,
                                input logic [1:0] b, input logic [2:0] alu, input logic ill,
                                input logic [6:0] o);
        out_t r;
        r.pc_write = pcw;   r.adr_src = adr;     r.mem_write = mw;
        r.ir_write = irw;   r.reg_write = rw;    r.result_src = res;
        r.alu_src_a = a;    r.alu_src_b = b;     r.alu_control = alu;
        r.imm_src = ref_imm(o);                  r.illegal = ill;
        return r;
    endfunction

    // Expected per-cycle outputs for one whole instruction.
    task automatic build_trace(input logic [31:0] ins, input logic z);
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7;
        logic       known;
        o = ins[6:0]; f3 = ins[14:12]; f7 = ins[30];
        known = (o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b1101111, 7'b0110111});
        exp_q.push_back(mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, o));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, !known, o));
        case (o)
            7'b0000011: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, o));
                exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, o));
            end
            7'b0100011: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, o));
                exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
            end
            7'b0110011, 7'b0010011: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, (o == 7'b0010011) ? 2'b01 : 2'b00,
                                   ref_alu(o, f3, f7), 0, o));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
            end
            7'b1100011:
                exp_q.push_back(mk(z ^ f3[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, o));
            7'b1101111: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, o));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
            end
            7'b0110111: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b000, 0, o));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, o));
            end
            default: ;
        endcase
    endtask

    // Starts just after an edge with the DUT in FETCH; returns once it is back in FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic z, output int lat,
                             output int nreg, output int nmem, output int npc,
                             output int nill, output logic [2:0] alu3);
        out_t e;
        lat = 0; nreg = 0; nmem = 0; npc = 0; nill = 0; alu3 = 3'b111;
        op = ins[6:0]; funct3 = ins[14:12]; funct7b5 = ins[30]; zero = z;
        seen_st.delete();
        build_trace(ins, z);
        forever begin
            @(negedge clk);
            seen_st.push_back(state_o);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("instr %08h cycle %0d outputs", ins, lat + 1), got, e);
            end else begin
                check($sformatf("instr %08h extra cycle %0d", ins, lat + 1), 1, 0);
            end
            nreg += int'(reg_write); nmem += int'(mem_write);
            npc += int'(pc_write);   nill += int'(illegal);
            if (lat == 2) alu3 = alu_control;
            lat++;
            @(posedge clk); #1;
            if (state_o == FETCH) break;
            if (lat >= 12) begin
                check($sformatf("instr %08h timeout", ins), 1, 0);
                break;
            end
        end
        check($sformatf("instr %08h missing cycles", ins), exp_q.size(), 0);
        exp_q.delete();
    endtask

    vec_t vecs[12];

    initial begin
        int         lat, nreg, nmem, npc, nill;
        logic [2:0] alu3;
        logic [31:0] ins;
        logic [6:0]  opl[8];
        state_e      lw_st[5];

        vecs[0]  = '{32'h0080A283, 1'b0, 5, 1, 0, 1, 0, 3'b000}; // lw
        vecs[1]  = '{32'h0020A423, 1'b0, 4, 0, 1, 1, 0, 3'b000}; // sw
        vecs[2]  = '{32'h002081B3, 1'b0, 4, 1, 0, 1, 0, 3'b000}; // add
        vecs[3]  = '{32'h402081B3, 1'b1, 4, 1, 0, 1, 0, 3'b001}; // sub
        vecs[4]  = '{32'hC0500093, 1'b0, 4, 1, 0, 1, 0, 3'b000}; // addi, bit30 set
        vecs[5]  = '{32'h0020A1B3, 1'b0, 4, 1, 0, 1, 0, 3'b101}; // slt
        vecs[6]  = '{32'h00208463, 1'b1, 3, 0, 0, 2, 0, 3'b001}; // beq taken
        vecs[7]  = '{32'h00208463, 1'b0, 3, 0, 0, 1, 0, 3'b001}; // beq not taken
        vecs[8]  = '{32'h00209463, 1'b1, 3, 0, 0, 1, 0, 3'b001}; // bne not taken
        vecs[9]  = '{32'h008000EF, 1'b0, 4, 1, 0, 2, 0, 3'b000}; // jal x1,8
        vecs[10] = '{32'h123452B7, 1'b0, 4, 1, 0, 1, 0, 3'b000}; // lui
        vecs[11] = '{32'h0000007F, 1'b0, 2, 0, 0, 1, 1, 3'b000}; // illegal op

        // Reset held: selects at FETCH values, every write enable low.
        op = 7'b0000011;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", got, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 7'b0000011));
        check("reset state", state_o, FETCH);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].instr, vecs[i].z, lat, nreg, nmem, npc, nill, alu3);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d reg_write cycles", i), nreg, vecs[i].nreg);
            check($sformatf("vec%0d mem_write cycles", i), nmem, vecs[i].nmem);
            check($sformatf("vec%0d pc_write cycles", i), npc, vecs[i].npc);
            check($sformatf("vec%0d illegal cycles", i), nill, vecs[i].nill);
            if (vecs[i].lat > 2) check($sformatf("vec%0d alu_control", i), alu3, vecs[i].alu3);
        end

        // lw state walk.
        lw_st = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB};
        run_instr(32'h0080A283, 1'b0, lat, nreg, nmem, npc, nill, alu3);
        check("lw state count", seen_st.size(), 5);
        foreach (lw_st[i])
            if (i < seen_st.size()) check($sformatf("lw state %0d", i), seen_st[i], lw_st[i]);

        // Reset while a store sits in MEMADR: no write may escape.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre-reset state MEMADR", state_o, MEMADR);
        rst = 1'b1;
        #1;
        check("mid-reset outputs", got, mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 7'b0100011));
        @(posedge clk); #1;
        check("post-reset state", state_o, FETCH);
        check("post-reset mem_write", mem_write, 0);
        rst = 1'b0;
        run_instr(32'h123452B7, 1'b0, lat, nreg, nmem, npc, nill, alu3);
        check("post-reset lui latency", lat, 4);

        // Random instructions against the model.
        opl = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b0110111, 7'b0000000};
        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom_range(0, 7);
            ins = $urandom;
            if (k < 7) begin
                ins[6:0] = opl[k];
            end else begin
                do ins[6:0] = 7'($urandom);
                while (ins[6:0] inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                        7'b1100011, 7'b1101111, 7'b0110111});
            end
            run_instr(ins, 1'($urandom_range(0, 1)), lat, nreg, nmem, npc, nill, alu3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 op  in  7  opcode from the instruction register (instr[6:0]).
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7b5  in  1  instr[30].
REQ-007 zero  in  1  ALU zero flag of the current cycle.
REQ-008 pc_write  out  1  PC register enable.
REQ-009 adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_write  out  1  data memory write enable.
REQ-011 ir_write  out  1  instruction register and OldPC enable.
REQ-012 reg_write  out  1  register file write enable.
REQ-013 result_src  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 alu_src_a  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
REQ-015 alu_src_b  out  2  SrcB select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-016 alu_control  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-017 imm_src  out  3  immediate generator format: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
REQ-018 illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-019 The block SHALL be a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, LUI.
REQ-020 State transitions SHALL be:
- FETCH -> DECODE.
- DECODE, by op: 0000011 / 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI; any other op -> FETCH.
- MEMADR: -> MEMREAD if op = 0000011, else -> MEMWRITE.
- MEMREAD -> MEMWB.
- EXECUTER, EXECUTEI, JAL and LUI -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
REQ-021 Per-state outputs SHALL be as follows; any field not listed is 0:
- FETCH: ir_write = 1, pc_update = 1, a = 00, b = 10, alu_op = 00, result_src = 10.
- DECODE: a = 01, b = 01, alu_op = 00.
- MEMADR: a = 10, b = 01, alu_op = 00.
- MEMREAD: adr_src = 1.
- MEMWB: result_src = 01, reg_write = 1.
- MEMWRITE: adr_src = 1, mem_write = 1.
- EXECUTER: a = 10, b = 00, alu_op = 10.
- EXECUTEI: a = 10, b = 01, alu_op = 10.
- ALUWB: reg_write = 1.
- BRANCH: a = 10, b = 00, alu_op = 01, branch = 1.
- JAL: a = 01, b = 10, alu_op = 00, pc_update = 1.
- LUI: a = 11, b = 01, alu_op = 00.
REQ-022 pc_write SHALL equal pc_update OR (branch AND (zero XOR funct3[0])), so beq is taken on zero = 1 and bne on zero = 0; this output is combinational on zero.
REQ-023 alu_control SHALL decode as follows:
- alu_op 00 -> 000; alu_op 01 -> 001.
- alu_op 10, by funct3: 000 -> 001 if (op[5] AND funct7b5), else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
REQ-024 imm_src SHALL decode combinationally from op in every state:
- 0000011 / 0010011 -> 000; 0100011 -> 001; 1100011 -> 010; 0110111 -> 011; 1101111 -> 100; any other op -> 000.
REQ-025 illegal SHALL be 1 only in DECODE with an unsupported op, lasting exactly one cycle.
REQ-026 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, I-ALU 4, branch 3, jal 4, lui 4, illegal 2.

Reset
REQ-027 While rst = 1 at a clock edge, the state SHALL become FETCH, regardless of the current state.
REQ-028 While rst = 1, pc_write, ir_write, mem_write, reg_write and illegal SHALL be forced to 0; the other outputs follow the FETCH values.
REQ-029 A reset asserted mid-instruction SHALL abandon that instruction with no further write enables; the first post-reset cycle is FETCH.

Structure
REQ-030 The shared package mc_pkg SHALL hold the state enum, the opcode constants, the imm_src format constants and the alu_control encodings.
REQ-031 The ALU decoder (REQ-023) SHALL be a separate combinational sub-module named alu_decoder.
REQ-032 The state register SHALL be the only sequential element.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- lw x5,8(x1) (0x0080A283) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write only in cycle 5; imm_src = 000.
- sw x2,8(x1) (0x0020A423) -> 4 cycles; mem_write high only in MEMWRITE; imm_src = 001.
- add (0x002081B3) -> alu_control = 000 in EXECUTER; sub (0x402081B3) -> alu_control = 001.
- beq, op 1100011 with funct3 000 and zero = 1 -> pc_write = 1 in BRANCH; bne with funct3 001 and zero = 1 -> pc_write = 0.
- jal x1,8 (0x008000EF) -> imm_src = 100; pc_write in FETCH and JAL; reg_write in ALUWB.
- op 0x7F -> illegal pulses for 1 cycle, returns to FETCH; separately, rst in MEMADR -> next state FETCH, no mem_write.
